fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO (16-bit, depth 8) among N_REQ requesters.
- Sits between the requester blocks and the FIFO write side (data_in, wr_en, full, almostfull, wr_ack, overflow).
- Issues at most one write per cycle and throttles on full/almostfull so the FIFO never overflows.
- Reports its arbitration state and a sticky error if the FIFO still flags overflow.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data width; must match the FIFO.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester valid; held with its data until granted.
- req_data  input  N_REQ*FIFO_WIDTH  packed data; slice i = bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  output  N_REQ  registered one-hot; bit i high for one cycle = requester i's data was taken.
- fifo_data_in  output  FIFO_WIDTH  registered write data to the FIFO.
- fifo_wr_en  output  1  registered write enable to the FIFO.
- fifo_full  input  1  FIFO full.
- fifo_almostfull  input  1  FIFO at DEPTH-1 entries.
- fifo_wr_ack  input  1  FIFO write accepted.
- fifo_overflow  input  1  FIFO write rejected.
- arb_state  output  2  00 IDLE, 01 ISSUE, 10 STALL.
- err  output  1  sticky; set on any fifo_overflow.

Behaviour:
- Reset values, applied asynchronously: gnt=0, fifo_data_in=0, fifo_wr_en=0, arb_state=IDLE, err=0, RR pointer=0.
- Reset asserted mid-transfer drops any pending write immediately. No write is replayed after reset.
- All decisions are made at the rising edge of clk, using these values just before the edge: req, fifo_full, fifo_almostfull, and the current fifo_wr_en / gnt.
- Eligible set = req & ~gnt. A requester granted in the current cycle is masked for one edge, which gives it time to drop or update req.
- Blocked = fifo_full | (fifo_almostfull & fifo_wr_en). This is conservative: read-side activity is ignored.
- Selection when eligible != 0 and not blocked:
  - Winner = first eligible index at or after the pointer, wrapping modulo N_REQ.
  - fifo_data_in <= slice[winner]; fifo_wr_en <= 1; gnt <= onehot(winner); pointer <= (winner+1) mod N_REQ; arb_state <= ISSUE.
- Eligible != 0 and blocked: fifo_wr_en <= 0, gnt <= 0, pointer unchanged, arb_state <= STALL. fifo_data_in holds its last value.
- Eligible == 0: fifo_wr_en <= 0, gnt <= 0, arb_state <= IDLE.
- Latency: req seen at edge k gives gnt and fifo_wr_en high during cycle k..k+1; the FIFO commits at edge k+1.
- Throughput: 1 write/cycle with at least 2 eligible requesters. A single requester gets 1 write per 2 cycles because of the mask.
- Pointer wraps from N_REQ-1 to 0.
- err <= 1 on any cycle with fifo_overflow=1; cleared only by reset. fifo_wr_ack is monitored only; see the optional feature.
- Requester protocol, which the bench checks: data must stay stable while req=1 and gnt[i]=0. Dropping req before the grant is legal; the request is then simply withdrawn.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined, two output ports are added:
  - ack_cnt [15:0]: counts fifo_wr_ack cycles.
  - stall_cnt [15:0]: counts cycles in STALL.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with req=4'b1111 -> gnt=0, fifo_wr_en=0, arb_state=00, err=0 asynchronously, before the next clk edge.
- Round-robin: req=4'b1111 held, FIFO empty, with reads draining -> grants in order 0,1,2,3,0,...; each write carries the matching slice (e.g. 16'hA000+i). No requester is granted in two consecutive cycles.
- Single requester: req=4'b0100, data 16'h1234 -> gnt=4'b0100 every other cycle and 16'h1234 written each time. arb_state alternates ISSUE/IDLE.
- Backpressure: no reads, req=4'b0011 -> exactly 8 writes are issued, then arb_state=STALL with fifo_wr_en=0. fifo_overflow is never seen and err stays 0. One read causes exactly one more write.
- Wrap/skip: pointer=3, req=4'b0010 -> winner 1, pointer becomes 2. Then req=4'b1001 -> winner 3, pointer becomes 0.
- Error/stats: force fifo_overflow=1 for one cycle -> err=1 until reset. With FIFO_ARB_STATS_EN defined, 10 acknowledged writes give ack_cnt=10, and a 5-cycle STALL gives stall_cnt=5.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ requesters.
// Define FIFO_ARB_STATS_EN to add the ack_cnt / stall_cnt statistics outputs.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  output logic                        fifo_wr_en,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic [1:0]                  arb_state,
  output logic                        err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                 ack_cnt,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;

  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic [N_REQ-1:0]      eligible;
  logic                  blocked;
  logic                  found;
  logic [PTR_W-1:0]      winner;

  // Last cycle's grantee is masked so it has one edge to drop or update req.
  assign eligible = req & ~gnt_q;
  // Conservative: ignores any read that may free a slot this cycle.
  assign blocked  = fifo_full | (fifo_almostfull & wr_en_q);

  // Rotating priority search starting at the pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    for (int off = 0; off < N_REQ; off++) begin
      logic [PTR_W:0] sum;
      logic [PTR_W:0] idx;
      sum = {1'b0, ptr_q} + (PTR_W + 1)'(off);
      idx = (sum >= (PTR_W + 1)'(N_REQ)) ? sum - (PTR_W + 1)'(N_REQ) : sum;
      if (!found && eligible[idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d   = '0;
    data_d  = data_q;
    wr_en_d = 1'b0;
    ptr_d   = ptr_q;
    state_d = ST_IDLE;
    err_d   = err_q | fifo_overflow;
    if (found && !blocked) begin
      gnt_d[winner] = 1'b1;
      data_d        = req_data[int'(winner)*FIFO_WIDTH +: FIFO_WIDTH];
      wr_en_d       = 1'b1;
      ptr_d         = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      state_d       = ST_ISSUE;
    end else if (found) begin
      state_d = ST_STALL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every flop here is control/output state, so all of them take the async reset;
  // a pending write is dropped rather than replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      state_q <= state_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_data_in = data_q;
  assign fifo_wr_en   = wr_en_q;
  assign arb_state    = state_q;
  assign err          = err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    ack_cnt_d   = ack_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fifo_wr_ack && ack_cnt_q != 16'hFFFF)
      ack_cnt_d = ack_cnt_q + 16'd1;
    if (state_q == ST_STALL && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ack_cnt_q   <= ack_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ack_cnt   = ack_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_wr_ack;
  assign unused_wr_ack = fifo_wr_ack;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small depth-8 FIFO model on the write side.
// Build with FIFO_ARB_STATS_EN defined to also check the statistics counters.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic [1:0]     arb_state;
  logic           err;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    ack_cnt;
  logic [15:0]    stall_cnt;
`endif

  logic           rd_en = 1'b0;
  logic           force_ovf = 1'b0;
  int             count;
  int             wr_total;
  logic           ack_q;
  logic           ovf_q;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_data_in    (fifo_data_in),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .arb_state       (arb_state),
    .err             (err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .ack_cnt         (ack_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Depth-8 FIFO occupancy model: writes rejected when full, reads only when non-empty.
  assign fifo_full       = (count == DEPTH);
  assign fifo_almostfull = (count == DEPTH - 1);
  assign fifo_wr_ack     = ack_q;
  assign fifo_overflow   = ovf_q | force_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 0;
      wr_total <= 0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      logic wr_ok, rd_ok;
      wr_ok = fifo_wr_en && (count < DEPTH);
      rd_ok = rd_en && (count > 0);
      count    <= count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
      wr_total <= wr_total + (wr_ok ? 1 : 0);
      ack_q    <= wr_ok;
      ovf_q    <= fifo_wr_en && (count == DEPTH);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] val);
    req_data[idx*W +: W] = val;
  endtask

  // One expected output beat: gnt, write data, write enable, state.
  task automatic expect_beat(input string tag, input logic [N-1:0] g, input logic [W-1:0] d,
                             input logic we, input logic [1:0] st);
    check({tag, ".gnt"},   32'(gnt), 32'(g));
    check({tag, ".data"},  32'(fifo_data_in), 32'(d));
    check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(we));
    check({tag, ".state"}, 32'(arb_state), 32'(st));
  endtask

  initial begin
    // Reset values.
    #2;
    check("rst.gnt",   32'(gnt), 32'h0);
    check("rst.wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst.state", 32'(arb_state), 32'h0);
    check("rst.err",   32'(err), 32'h0);
    check("rst.data",  32'(fifo_data_in), 32'h0);
    #4 rst_n = 1'b1;

    // Round-robin with all four requesting and reads draining.
    for (int i = 0; i < N; i++) set_data(i, 16'hA000 + 16'(i));
    rd_en = 1'b1;
    req   = 4'b1111;
    step(); expect_beat("rr0", 4'b0001, 16'hA000, 1'b1, 2'b01);
    step(); expect_beat("rr1", 4'b0010, 16'hA001, 1'b1, 2'b01);
    step(); expect_beat("rr2", 4'b0100, 16'hA002, 1'b1, 2'b01);
    step(); expect_beat("rr3", 4'b1000, 16'hA003, 1'b1, 2'b01);
    step(); expect_beat("rr4", 4'b0001, 16'hA000, 1'b1, 2'b01);
    step(); expect_beat("rr5", 4'b0010, 16'hA001, 1'b1, 2'b01);
    check("rr.err", 32'(err), 32'h0);

    // Sticky error from a one-cycle overflow flag.
    force_ovf = 1'b1;
    step();
    force_ovf = 1'b0;
    check("ovf.err_set", 32'(err), 32'h1);
    step();
    check("ovf.err_sticky", 32'(err), 32'h1);
    step();
    check("ovf.err_sticky2", 32'(err), 32'h1);

    // Asynchronous reset mid-cycle while all requesters are active.
    #2 rst_n = 1'b0;
    #1;
    check("arst.gnt",   32'(gnt), 32'h0);
    check("arst.wr_en", 32'(fifo_wr_en), 32'h0);
    check("arst.state", 32'(arb_state), 32'h0);
    check("arst.err",   32'(err), 32'h0);
    check("arst.data",  32'(fifo_data_in), 32'h0);
    req = 4'b0100;
    set_data(2, 16'h1234);
    #1 rst_n = 1'b1;

    // Single requester: one write every other cycle.
    step(); expect_beat("one0", 4'b0100, 16'h1234, 1'b1, 2'b01);
    step(); expect_beat("one1", 4'b0000, 16'h1234, 1'b0, 2'b00);
    step(); expect_beat("one2", 4'b0100, 16'h1234, 1'b1, 2'b01);
    step(); expect_beat("one3", 4'b0000, 16'h1234, 1'b0, 2'b00);

    // Wrap/skip: pointer is 3 here.
    for (int i = 0; i < N; i++) set_data(i, 16'hB000 + 16'(i));
    req = 4'b0010;
    step(); expect_beat("wrap0", 4'b0010, 16'hB001, 1'b1, 2'b01);
    req = 4'b1001;
    step(); expect_beat("wrap1", 4'b1000, 16'hB003, 1'b1, 2'b01);
    step(); expect_beat("wrap2", 4'b0001, 16'hB000, 1'b1, 2'b01);
    req = 4'b0000;
    step(); expect_beat("wrap3", 4'b0000, 16'hB000, 1'b0, 2'b00);

    // Backpressure: fresh reset, no reads, two requesters.
    rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    set_data(0, 16'hC000);
    set_data(1, 16'hC001);
    req = 4'b0011;
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("bp.issue_wr_en", 32'(fifo_wr_en), 32'h1);
    end
    step(); expect_beat("bp8",  4'b0010, 16'hC001, 1'b1, 2'b01);
    step(); expect_beat("bp9",  4'b0000, 16'hC001, 1'b0, 2'b10);
    check("bp.count_full", 32'(count), 32'(DEPTH));
    for (int i = 10; i <= 14; i++) begin
      step();
      check("bp.stall_state", 32'(arb_state), 32'h2);
    end
    check("bp.writes8", 32'(wr_total), 32'd8);
    check("bp.err", 32'(err), 32'h0);
`ifdef FIFO_ARB_STATS_EN
    check("stats.ack_cnt",   32'(ack_cnt), 32'd8);
    check("stats.stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // One read frees exactly one slot.
    rd_en = 1'b1;
    step(); expect_beat("bp15", 4'b0000, 16'hC001, 1'b0, 2'b10);
    rd_en = 1'b0;
    step(); expect_beat("bp16", 4'b0001, 16'hC000, 1'b1, 2'b01);
    step(); expect_beat("bp17", 4'b0000, 16'hC000, 1'b0, 2'b10);
    step(); expect_beat("bp18", 4'b0000, 16'hC000, 1'b0, 2'b10);
    check("bp.writes9", 32'(wr_total), 32'd9);
    check("bp.err_end", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
